// File: rtl/sample_iterator.sv
// Walks every subsample position of a snapped bounding box in raster order,
// one sample per cycle, carrying the owning triangle and color alongside.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic                     validTri_R13H,
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     ready_R13H,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H,
    output logic                     dbg_state_o
);

    // Handshake: a triangle transfers on a clock edge where validTri_R13H and
    // ready_R13H are both 1; upstream holds its inputs until that edge.
    typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_e;

    state_e                   state_q, state_d;
    logic signed [SIGFIG-1:0] x_q, x_d, y_q, y_d;
    logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
    logic        [SIGFIG-1:0] step_q, step_d;
    logic                     degen_q, degen_d;
    logic                     valid_q, valid_d;
    logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
    logic signed [SIGFIG-1:0] tri_d [VERTS][AXIS];
    logic        [SIGFIG-1:0] color_q [COLORS];
    logic        [SIGFIG-1:0] color_d [COLORS];

    logic        [1:0]        ss_lg2;
    logic        [SIGFIG-1:0] step_new;
    logic signed [SIGFIG:0]   x_inc, y_inc;
    logic                     x_fits, y_fits, last, accept;

    // Lowest set bit wins; all-zero falls through to 1x.
    always_comb begin
        ss_lg2 = 2'd0;
        if (subSample_RnnnnU[0])      ss_lg2 = 2'd3;
        else if (subSample_RnnnnU[1]) ss_lg2 = 2'd2;
        else if (subSample_RnnnnU[2]) ss_lg2 = 2'd1;
        step_new = {{(SIGFIG-1){1'b0}}, 1'b1} << (RADIX - int'(ss_lg2));
    end

    // One extra bit keeps position+step from wrapping near positive full scale.
    assign x_inc  = $signed({x_q[SIGFIG-1], x_q}) + $signed({1'b0, step_q});
    assign y_inc  = $signed({y_q[SIGFIG-1], y_q}) + $signed({1'b0, step_q});
    assign x_fits = x_inc <= $signed({urx_q[SIGFIG-1], urx_q});
    assign y_fits = y_inc <= $signed({ury_q[SIGFIG-1], ury_q});

    assign last       = (state_q == TEST) && (degen_q || (!x_fits && !y_fits));
    assign ready_R13H = rst && ((state_q == WAIT) || last);
    assign accept     = validTri_R13H && ready_R13H;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        llx_d   = llx_q;
        urx_d   = urx_q;
        ury_d   = ury_q;
        step_d  = step_q;
        degen_d = degen_q;
        valid_d = valid_q;
        tri_d   = tri_q;
        color_d = color_q;
        if (accept) begin
            state_d = TEST;
            valid_d = 1'b1;
            x_d     = box_R13S[0][0];
            y_d     = box_R13S[0][1];
            llx_d   = box_R13S[0][0];
            urx_d   = box_R13S[1][0];
            ury_d   = box_R13S[1][1];
            step_d  = step_new;
            degen_d = (box_R13S[0][0] > box_R13S[1][0]) ||
                      (box_R13S[0][1] > box_R13S[1][1]);
            tri_d   = tri_R13S;
            color_d = color_R13U;
        end else if (state_q == TEST) begin
            // An inverted box emits only its LL corner.
            if (degen_q) begin
                state_d = WAIT;
                valid_d = 1'b0;
            end else if (x_fits) begin
                x_d = x_inc[SIGFIG-1:0];
            end else if (y_fits) begin
                x_d = llx_q;
                y_d = y_inc[SIGFIG-1:0];
            end else begin
                state_d = WAIT;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            llx_q   <= '0;
            urx_q   <= '0;
            ury_q   <= '0;
            step_q  <= '0;
            degen_q <= 1'b0;
            tri_q   <= '{default: '{default: '0}};
            color_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
            llx_q   <= llx_d;
            urx_q   <= urx_d;
            ury_q   <= ury_d;
            step_q  <= step_d;
            degen_q <= degen_d;
            tri_q   <= tri_d;
            color_q <= color_d;
        end
    end

    assign tri_R14S       = tri_q;
    assign color_R14U     = color_q;
    assign sample_R14S[0] = x_q;
    assign sample_R14S[1] = y_q;
    assign validSamp_R14H = valid_q;
    assign dbg_state_o    = (state_q == TEST);

endmodule

// File: tb/tb_sample_iterator.sv
// Directed bench for sample_iterator: each task drives one scenario and checks
// outputs 1 time unit after the rising edge against hand-computed values.
module tb_sample_iterator;
    localparam int SIGFIG = 24;

    logic                     clk = 1'b0;
    logic                     rst;
    logic signed [SIGFIG-1:0] tri_in [3][3];
    logic        [SIGFIG-1:0] color_in [3];
    logic                     valid_tri;
    logic signed [SIGFIG-1:0] box_in [2][2];
    logic        [3:0]        sub_sample;
    logic                     ready;
    logic signed [SIGFIG-1:0] tri_out [3][3];
    logic        [SIGFIG-1:0] color_out [3];
    logic signed [SIGFIG-1:0] sample_out [2];
    logic                     valid_samp;
    logic                     dbg_state;

    int vectors = 0;
    int miscompares = 0;

    sample_iterator dut (
        .clk(clk), .rst(rst),
        .tri_R13S(tri_in), .color_R13U(color_in), .validTri_R13H(valid_tri),
        .box_R13S(box_in), .subSample_RnnnnU(sub_sample),
        .ready_R13H(ready), .tri_R14S(tri_out), .color_R14U(color_out),
        .sample_R14S(sample_out), .validSamp_R14H(valid_samp),
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int lx, input int ly, input int ux, input int uy,
                        input logic [3:0] ss, input int fill);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++) tri_in[v][a] = SIGFIG'(fill);
        for (int c = 0; c < 3; c++) color_in[c] = SIGFIG'(fill + 100);
        box_in[0][0] = SIGFIG'(lx);
        box_in[0][1] = SIGFIG'(ly);
        box_in[1][0] = SIGFIG'(ux);
        box_in[1][1] = SIGFIG'(uy);
        sub_sample = ss;
        valid_tri = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        vectors++;
        if (valid_samp !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", valid_samp); end
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b expected 0", ready); end
        vectors++;
        if (sample_out[0] !== 0 || sample_out[1] !== 0 || tri_out[2][2] !== 0 || color_out[0] !== 0) begin
            miscompares++; $display("FAIL reset_clear: got x=%0d y=%0d tri=%0d col=%0d expected all 0",
                                    sample_out[0], sample_out[1], tri_out[2][2], color_out[0]);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %0b expected 1", ready); end
    endtask

    task automatic test_1x();
        int ex [6];
        int ey [6];
        ex = '{0, 1024, 2048, 0, 1024, 2048};
        ey = '{0, 0, 0, 1024, 1024, 1024};
        load(0, 0, 2048, 1024, 4'b1000, 1);
        tick();
        valid_tri = 1'b0;
        vectors++;
        if (tri_out[1][2] !== 1 || color_out[2] !== 101) begin
            miscompares++; $display("FAIL 1x_tri_color: got %0d/%0d expected 1/101", tri_out[1][2], color_out[2]);
        end
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (valid_samp !== 1'b1 || sample_out[0] !== SIGFIG'(ex[k]) || sample_out[1] !== SIGFIG'(ey[k])) begin
                miscompares++; $display("FAIL 1x_sample%0d: got v=%0b (%0d,%0d) expected v=1 (%0d,%0d)",
                                        k, valid_samp, sample_out[0], sample_out[1], ex[k], ey[k]);
            end
            vectors++;
            if (ready !== (k == 5)) begin
                miscompares++; $display("FAIL 1x_ready%0d: got %0b expected %0b", k, ready, k == 5);
            end
            tick();
        end
        vectors++;
        if (valid_samp !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("FAIL 1x_done: got v=%0b r=%0b expected v=0 r=1", valid_samp, ready);
        end
    endtask

    task automatic test_single();
        load(5120, 3072, 5120, 3072, 4'b1000, 4);
        tick();
        valid_tri = 1'b0;
        vectors++;
        if (valid_samp !== 1'b1 || sample_out[0] !== 5120 || sample_out[1] !== 3072 || ready !== 1'b1) begin
            miscompares++; $display("FAIL single_sample: got v=%0b (%0d,%0d) r=%0b expected v=1 (5120,3072) r=1",
                                    valid_samp, sample_out[0], sample_out[1], ready);
        end
        tick();
        vectors++;
        if (valid_samp !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("FAIL single_done: got v=%0b r=%0b expected v=0 r=1", valid_samp, ready);
        end
    endtask

    task automatic test_64x();
        int ex [6];
        int ey [6];
        ex = '{0, 128, 256, 0, 128, 256};
        ey = '{0, 0, 0, 128, 128, 128};
        load(0, 0, 256, 128, 4'b0001, 3);
        tick();
        valid_tri = 1'b0;
        sub_sample = 4'b1000;
        for (int k = 0; k < 6; k++) begin
            vectors++;
            if (valid_samp !== 1'b1 || sample_out[0] !== SIGFIG'(ex[k]) || sample_out[1] !== SIGFIG'(ey[k])
                || ready !== (k == 5)) begin
                miscompares++; $display("FAIL 64x_sample%0d: got v=%0b (%0d,%0d) r=%0b expected v=1 (%0d,%0d) r=%0b",
                                        k, valid_samp, sample_out[0], sample_out[1], ready, ex[k], ey[k], k == 5);
            end
            tick();
        end
        vectors++;
        if (valid_samp !== 1'b0) begin miscompares++; $display("FAIL 64x_done: got v=%0b expected 0", valid_samp); end
    endtask

    task automatic test_degenerate();
        load(2048, 0, 1024, 1024, 4'b1000, 5);
        tick();
        valid_tri = 1'b0;
        vectors++;
        if (valid_samp !== 1'b1 || sample_out[0] !== 2048 || sample_out[1] !== 0) begin
            miscompares++; $display("FAIL degen_sample: got v=%0b (%0d,%0d) expected v=1 (2048,0)",
                                    valid_samp, sample_out[0], sample_out[1]);
        end
        tick();
        vectors++;
        if (valid_samp !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("FAIL degen_done: got v=%0b r=%0b expected v=0 r=1", valid_samp, ready);
        end
    endtask

    task automatic test_back_to_back();
        int ex [3];
        ex = '{0, 1024, 2048};
        load(0, 0, 2048, 0, 4'b1000, 6);
        tick();
        load(7168, 7168, 7168, 7168, 4'b1000, 7);
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (valid_samp !== 1'b1 || sample_out[0] !== SIGFIG'(ex[k]) || sample_out[1] !== 0
                || ready !== (k == 2) || tri_out[0][1] !== 6) begin
                miscompares++; $display("FAIL b2b_busy%0d: got v=%0b (%0d,%0d) r=%0b tri=%0d expected v=1 (%0d,0) r=%0b tri=6",
                                        k, valid_samp, sample_out[0], sample_out[1], ready, tri_out[0][1], ex[k], k == 2);
            end
            tick();
        end
        vectors++;
        if (valid_samp !== 1'b1 || sample_out[0] !== 7168 || sample_out[1] !== 7168
            || tri_out[0][1] !== 7 || color_out[1] !== 107) begin
            miscompares++; $display("FAIL b2b_next: got v=%0b (%0d,%0d) tri=%0d col=%0d expected v=1 (7168,7168) tri=7 col=107",
                                    valid_samp, sample_out[0], sample_out[1], tri_out[0][1], color_out[1]);
        end
        valid_tri = 1'b0;
        tick();
        vectors++;
        if (valid_samp !== 1'b0 || ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_once: got v=%0b r=%0b expected v=0 r=1", valid_samp, ready);
        end
    endtask

    task automatic test_reset_mid_box();
        load(0, 0, 2048, 1024, 4'b1000, 8);
        tick();
        valid_tri = 1'b0;
        tick();
        tick();
        vectors++;
        if (valid_samp !== 1'b1 || sample_out[0] !== 2048 || sample_out[1] !== 0) begin
            miscompares++; $display("FAIL mid_sample3: got v=%0b (%0d,%0d) expected v=1 (2048,0)",
                                    valid_samp, sample_out[0], sample_out[1]);
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (valid_samp !== 1'b0 || ready !== 1'b0 || tri_out[0][0] !== 0 || sample_out[0] !== 0) begin
            miscompares++; $display("FAIL mid_reset: got v=%0b r=%0b tri=%0d x=%0d expected all 0",
                                    valid_samp, ready, tri_out[0][0], sample_out[0]);
        end
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (valid_samp !== 1'b0 || ready !== 1'b1) begin
                miscompares++; $display("FAIL mid_after%0d: got v=%0b r=%0b expected v=0 r=1", k, valid_samp, ready);
            end
        end
    endtask

    initial begin
        valid_tri = 1'b0;
        sub_sample = 4'b1000;
        tri_in = '{default: '{default: '0}};
        color_in = '{default: '0};
        box_in = '{default: '{default: '0}};
        test_reset();
        test_1x();
        test_single();
        test_64x();
        test_degenerate();
        test_back_to_back();
        test_reset_mid_box();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sample_iterator.md
# sample_iterator

Rasterizer stage between bounding-box generation and the sample test. It accepts one triangle with its snapped bounding box, then walks every subsample position inside the box in raster order, emitting one sample per cycle with the triangle and color attached. Its sample, triangle and valid outputs feed the sample-test/hash pipeline whose hits the sample-count scoreboard counts. It back-pressures the bbox stage with a ready signal while a box is being walked.

## Interface
- SIGFIG, 24, bits in color and position
- RADIX, 10, fraction bits in position
- VERTS, 3, vertices per triangle
- AXIS, 3, axes per vertex
- COLORS, 3, color channels
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- tri_R13S  in  signed [SIGFIG-1:0] [VERTS][AXIS]  triangle from bbox stage
- color_R13U  in  [SIGFIG-1:0] [COLORS]  triangle color
- validTri_R13H  in  1  triangle and box valid
- box_R13S  in  signed [SIGFIG-1:0] [2][2]  box[0]=LL (x,y), box[1]=UR (x,y), snapped to sample grid
- subSample_RnnnnU  in  4  one-hot MSAA mode: bit3=1x, bit2=4x, bit1=16x, bit0=64x
- ready_R13H  out  1  stage accepts a triangle this cycle
- tri_R14S  out  signed [SIGFIG-1:0] [VERTS][AXIS]  latched triangle
- color_R14U  out  [SIGFIG-1:0] [COLORS]  latched color
- sample_R14S  out  signed [SIGFIG-1:0] [2]  current sample (x,y)
- validSamp_R14H  out  1  sample_R14S valid

## Operation
- ss_w_lg2 = 0/1/2/3 for subSample bit 3/2/1/0; step = 1 << (RADIX - ss_w_lg2). Non-one-hot values: the lowest set bit wins. All-zero selects 1x.
- Two states:
  - WAIT: idle.
  - TEST: iterating.
- ready_R13H = (state==WAIT) || last, where last = (x+step > URx) && (y+step > URy) in TEST.
- Accept when validTri_R13H && ready_R13H:
  - Latch tri, color and box. Latch step from subSample at acceptance; later changes do not affect the current box.
  - sample <= LL.
  - validSamp <= 1.
  - state <= TEST.
- In TEST with no acceptance:
  - If x+step <= URx: x += step.
  - Else if y+step <= URy: x = LLx, y += step.
  - Else (last): validSamp <= 0, state <= WAIT.
- Acceptance in the last cycle loads the next box directly, with no bubble.
- Additions are computed at SIGFIG+1 bits and compared signed, so no wrap-around occurs at positive full scale.
- validTri_R13H while ready_R13H=0 is ignored. Upstream must hold its inputs.
- LL > UR on either axis: the LL sample is still emitted once, then the stage returns to WAIT.
- tri_R14S and color_R14U hold constant for the whole box. A change marks a new triangle to downstream counters.

## Timing
- All outputs except ready_R13H are registered. ready_R13H is combinational from state and the position registers only, never from validTri_R13H.
- The first sample appears one cycle after acceptance.
- A box of N = nx*ny samples produces exactly N consecutive validSamp_R14H cycles.
- Reset (rst=0 at clk edge):
  - state=WAIT, validSamp_R14H=0.
  - sample, tri and color cleared to 0.
  - ready_R13H=0 while rst is low. It is 1 in the first cycle after release.
- Reset mid-box aborts the iteration. No further samples are emitted after release.

## Test plan
- 1x, box (0,0)-(2048,1024) -> samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles; ready_R13H=1 only in the 6th.
- Single-sample box LL=UR=(5120,3072) -> exactly one validSamp cycle at (5120,3072); ready_R13H stays 1.
- 64x (subSample=4'b0001), box (0,0)-(256,128), step 128 -> 6 samples ending at (256,128); switching subSample to 1x mid-box does not change the sequence.
- Back-to-back: triangle B held valid during A's last sample -> B's LL appears on the very next cycle; tri_R14S changes on that same cycle.
- Reset mid-box: rst=0 during sample 3 of 6 -> validSamp_R14H=0 at that edge; after release ready_R13H=1, with no samples until a new triangle is accepted.
- validTri_R13H asserted while busy with box C -> not accepted until the ready cycle; accepted exactly once.
